dec_scan_seq: RTL and testbench
===============================

Name: dec_scan_seq

Overview:
Upstream index sequencer for the 4-to-16 enabled decoder. It generates the 4-bit select `w` and the enable `e` that step the decoder's one-hot outputs through a programmable range. The range is 0..last, scanned up or down. Each index is held for a programmable dwell time, and one blanking cycle (e=0) separates consecutive indices. Supports continuous (wrapping) scans, one-shot scans with a completion pulse, and an abort input.

Parameters:
DWELL_W, 8, width of the dwell-count configuration input and internal dwell counter

Ports:
clk  input  1  system clock; all state changes on its rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  request to begin a scan; sampled only in IDLE
stop  input  1  abort the scan in progress; sampled in DWELL/BLANK
dir  input  1  0 = scan up (0→last), 1 = scan down (last→0); latched at start
oneshot  input  1  1 = single pass then stop; 0 = wrap continuously; latched at start
last  input  4  terminal (up) / initial (down) index; latched at start
dwell  input  DWELL_W  index hold time minus one, in cycles; latched at start
w  output  4  registered select to the decoder
e  output  1  registered enable to the decoder
busy  output  1  high in DWELL and BLANK
done  output  1  one-cycle pulse on one-shot completion

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst_n` is asynchronous and active-low. While rst_n=0: state=IDLE, w=0, e=0, busy=0, done=0, dwell counter=0, latched config=0. Reset asserted mid-scan aborts immediately with no done pulse.
- States: IDLE, DWELL, BLANK.
- IDLE, start=1 at an edge: latch dir, oneshot, last, dwell. At that edge set w = (dir ? last : 0), e=1, busy=1, counter=0, and go to DWELL. Latency from start to e=1 is one clock.
- DWELL: e=1 and w stable. The counter increments each cycle, so the index is held for dwell+1 cycles (dwell=0 gives 1 cycle). On the edge where counter==dwell_l:
  - Terminal index, oneshot=1: go to IDLE; e=0, busy=0, done=1 for one cycle; w holds the terminal value. The terminal index is w==last_l (up) or w==0 (down).
  - Otherwise: go to BLANK; e=0; w = next index; counter=0. Next index is w+1 (up) or w-1 (down). At the terminal index it wraps to the start value (0 for up, last_l for down).
- BLANK: exactly one cycle with e=0. At the next edge go to DWELL with e=1.
- Index period is dwell+2 cycles. w never changes while e=1.
- last=0: a degenerate one-index scan. Continuous mode pulses e on w=0 with one-cycle gaps. One-shot mode completes after one dwell.
- stop=1 in DWELL or BLANK: go to IDLE at the next edge with e=0, busy=0, done=0, and w holding. stop has priority over dwell expiry; stop in IDLE is ignored.
- start while busy is ignored. Config input changes while busy are ignored.
- done is asserted only on natural one-shot completion and never coincides with busy=1. A start in the cycle done is high is accepted (state is IDLE).
- All arithmetic is unsigned and modulo 16 on w. The counter is DWELL_W bits and never exceeds dwell_l.

Decomposition:
- Shared constants header (`dec_scan_defs.vh`): state encodings ST_IDLE=2'd0, ST_DWELL=2'd1, ST_BLANK=2'd2; default DWELL_W.
- One natural sub-module: `dwell_timer`. It takes clk, rst_n, load, limit[DWELL_W-1:0], and en, and outputs expire. It is a cleared-on-load up-counter flagging counter==limit.
- The FSM, index datapath, and config latches stay in `dec_scan_seq`.

Test Plan:
1. Reset/idle: assert rst_n=0 mid-DWELL with w=5 → w=0, e=0, busy=0, done=0 immediately, before any clock edge. After release with no start, outputs stay at reset values.
2. One-shot up: dwell=0, last=3, dir=0, oneshot=1, pulse start → e=1,0,1,0,1,0,1 with w=0,1,1,2,2,3,3; done=1 and busy=0 on the next cycle; exactly 4 e-high cycles.
3. Continuous down with dwell: dwell=2, last=2, dir=1, oneshot=0 → w holds 2 for 3 e-high cycles, then BLANK, then 1, then 0, then wraps to 2. Period is 4 cycles per index. done never asserts.
4. Stop priority: stop=1 on the same cycle the counter expires at w=4 → IDLE next edge, w=4, e=0, busy=0, done=0. No advance to 5.
5. Ignored inputs: change last/dwell/dir and pulse start mid-scan → sequence is unchanged. start on the done cycle → new scan begins next cycle with e=1.
6. Edge config: last=0, oneshot=1, dwell=255 → e=1 for 256 cycles at w=0, then done pulse. last=15, up, continuous → w wraps 15→0 with one blank cycle.

Source files
------------

// File: rtl/dec_scan_seq_pkg.sv
// Shared state encoding and default sizing for the decoder index sequencer.
package dec_scan_seq_pkg;

  localparam int unsigned DEF_DWELL_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

endpackage

// File: rtl/dec_scan_seq_dwell_timer.sv
// Cleared-on-load up-counter; expire flags counter == limit.
module dwell_timer #(
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [DWELL_W-1:0] limit,
  input  logic               en,
  output logic               expire
);

  logic [DWELL_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt <= '0;
    else if (load) cnt <= '0;
    else if (en)   cnt <= cnt + 1'b1;
  end

  assign expire = (cnt == limit);

endmodule

// File: rtl/dec_scan_seq.sv
// Index sequencer driving select/enable of a 4-to-16 decoder through 0..last.
module dec_scan_seq
  import dec_scan_seq_pkg::*;
#(
  parameter int unsigned DWELL_W = DEF_DWELL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               dir,
  input  logic               oneshot,
  input  logic [3:0]         last,
  input  logic [DWELL_W-1:0] dwell,
  output logic [3:0]         w,
  output logic               e,
  output logic               busy,
  output logic               done
);

  state_t             state_q, state_d;
  logic [3:0]         w_d;
  logic               e_d, busy_d, done_d;
  logic               dir_l, oneshot_l, dir_d, oneshot_d;
  logic [3:0]         last_l, last_d;
  logic [DWELL_W-1:0] dwell_l, dwell_d;
  logic               expire, tmr_load, at_term;
  logic [3:0]         w_next;

  // Counter is held clear outside DWELL and on any DWELL exit, so it never passes dwell_l.
  assign tmr_load = (state_q != ST_DWELL) || expire || stop;

  dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (tmr_load),
    .limit  (dwell_l),
    .en     (state_q == ST_DWELL),
    .expire (expire)
  );

  assign at_term = dir_l ? (w == 4'd0) : (w == last_l);
  assign w_next  = at_term ? (dir_l ? last_l : 4'd0)
                           : (dir_l ? w - 4'd1 : w + 4'd1);

  always_comb begin
    state_d   = state_q;
    w_d       = w;
    e_d       = e;
    busy_d    = busy;
    done_d    = 1'b0;
    dir_d     = dir_l;
    oneshot_d = oneshot_l;
    last_d    = last_l;
    dwell_d   = dwell_l;
    unique case (state_q)
      ST_IDLE: begin
        e_d    = 1'b0;
        busy_d = 1'b0;
        if (start) begin
          dir_d     = dir;
          oneshot_d = oneshot;
          last_d    = last;
          dwell_d   = dwell;
          w_d       = dir ? last : 4'd0;
          e_d       = 1'b1;
          busy_d    = 1'b1;
          state_d   = ST_DWELL;
        end
      end
      ST_DWELL: begin
        if (stop) begin
          e_d     = 1'b0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (expire) begin
          e_d = 1'b0;
          if (at_term && oneshot_l) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            w_d     = w_next;
            state_d = ST_BLANK;
          end
        end
      end
      ST_BLANK: begin
        if (stop) begin
          e_d     = 1'b0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          e_d     = 1'b1;
          state_d = ST_DWELL;
        end
      end
      default: begin
        e_d     = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      w         <= '0;
      e         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dir_l     <= 1'b0;
      oneshot_l <= 1'b0;
      last_l    <= '0;
      dwell_l   <= '0;
    end else begin
      state_q   <= state_d;
      w         <= w_d;
      e         <= e_d;
      busy      <= busy_d;
      done      <= done_d;
      dir_l     <= dir_d;
      oneshot_l <= oneshot_d;
      last_l    <= last_d;
      dwell_l   <= dwell_d;
    end
  end

endmodule

// File: tb/tb_dec_scan_seq.sv
// Directed bench for dec_scan_seq with hand-computed expected sequences.
module tb_dec_scan_seq;

  logic       clk, rst_n, start, stop, dir, oneshot;
  logic [3:0] last;
  logic [7:0] dwell;
  logic [3:0] w;
  logic       e, busy, done;

  int errors = 0;
  int checks = 0;

  dec_scan_seq #(.DWELL_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .stop    (stop),
    .dir     (dir),
    .oneshot (oneshot),
    .last    (last),
    .dwell   (dwell),
    .w       (w),
    .e       (e),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_outs(input string tag, input logic [3:0] wexp);
    chk({tag, ".w"}, w, wexp);
    chk({tag, ".e"}, e, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
  endtask

  task automatic go(input logic d, input logic os, input logic [3:0] l, input logic [7:0] dw);
    dir = d; oneshot = os; last = l; dwell = dw; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int ee[7] = '{1, 0, 1, 0, 1, 0, 1};
    int ww[7] = '{0, 1, 1, 2, 2, 3, 3};
    int sq[5] = '{2, 1, 0, 2, 1};

    rst_n = 1'b0; start = 0; stop = 0; dir = 0; oneshot = 0; last = 0; dwell = 0;
    #12;
    idle_outs("rst", 4'd0);
    rst_n = 1'b1;
    tick();

    // Reset mid-DWELL at w=5: asynchronous clear before any edge
    go(1'b0, 1'b0, 4'd15, 8'd0);
    for (int k = 0; k < 10; k++) tick();
    chk("pre_rst.w", w, 5);
    chk("pre_rst.e", e, 1);
    #2 rst_n = 1'b0;
    #1 idle_outs("async_rst", 4'd0);
    #3 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      idle_outs("post_rst", 4'd0);
    end

    // One-shot up, last=3, dwell=0
    go(1'b0, 1'b1, 4'd3, 8'd0);
    for (int k = 0; k < 7; k++) begin
      chk("os_up.e", e, ee[k]);
      chk("os_up.w", w, ww[k]);
      chk("os_up.busy", busy, 1);
      chk("os_up.done", done, 0);
      tick();
    end
    chk("os_up.done_pulse", done, 1);
    chk("os_up.busy_end", busy, 0);
    chk("os_up.e_end", e, 0);
    chk("os_up.w_hold", w, 3);

    // Start accepted on the done cycle: continuous down, last=2, dwell=2
    go(1'b1, 1'b0, 4'd2, 8'd2);
    for (int k = 0; k < 16; k++) begin
      chk("cdn.e", e, (k % 4) < 3);
      chk("cdn.w", w, ((k % 4) == 3) ? sq[k / 4 + 1] : sq[k / 4]);
      chk("cdn.busy", busy, 1);
      chk("cdn.done", done, 0);
      if (k == 5) begin
        start = 1'b1; last = 4'd9; dwell = 8'd0; dir = 1'b0; oneshot = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    chk("cdn.w16", w, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    idle_outs("cdn_stop", 4'd1);

    // Stop coincident with dwell expiry at w=4 (up, last=6, dwell=1)
    go(1'b0, 1'b0, 4'd6, 8'd1);
    for (int k = 0; k < 13; k++) tick();
    chk("stp.w_pre", w, 4);
    chk("stp.e_pre", e, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    idle_outs("stp", 4'd4);
    tick();
    idle_outs("stp_hold", 4'd4);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    idle_outs("stp_idle", 4'd4);

    // last=0 one-shot with maximum dwell: 256 enabled cycles then done
    go(1'b0, 1'b1, 4'd0, 8'd255);
    for (int k = 0; k < 256; k++) begin
      chk("long.e", e, 1);
      chk("long.w", w, 0);
      tick();
    end
    chk("long.done", done, 1);
    chk("long.e_end", e, 0);
    chk("long.busy_end", busy, 0);
    tick();
    chk("long.done_clr", done, 0);

    // last=15 up continuous: wrap 15 -> 0 with one blank cycle
    go(1'b0, 1'b0, 4'd15, 8'd0);
    for (int k = 0; k < 34; k++) begin
      chk("wrap.e", e, (k % 2) == 0);
      chk("wrap.w", w, ((k / 2) + (k % 2)) % 16);
      chk("wrap.done", done, 0);
      tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    idle_outs("wrap_stop", 4'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
